mult_product_accumulator: RTL and testbench

- Downstream stage of the 8x8 shift-and-add multiplier.
- Consumes a stream of 16-bit products over a valid/ready handshake and sums a programmable number of them into a saturating accumulator.
- Presents the block sum, with a sticky overflow flag, on a registered valid/ready output.
- Forms the accumulate half of the team's multiply-accumulate datapath.

---
 rtl/mult_product_accumulator.sv | 65 ++++++
 tb/tb_mult_product_accumulator.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mult_product_accumulator.sv
// mult_product_accumulator: sums blocks of unsigned products into a saturating accumulator with a valid/ready result port
module mult_product_accumulator #(
    parameter int PW = 16,
    parameter int AW = 24,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_data,
    input  logic [CW-1:0] len,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_sum,
    output logic          out_ovf,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
    state_t        state;
    logic [AW-1:0] acc;
    logic [CW-1:0] cnt;
    logic          ovf;
    logic [AW:0]   sum;
    logic [CW-1:0] eff_len;
    logic          in_fire;
    assign sum       = {1'b0, acc} + (AW+1)'(in_data);
    assign eff_len   = (len == '0) ? CW'(1) : len;
    assign in_fire   = in_valid & in_ready;
    assign in_ready  = state != HOLD;
    assign out_valid = state == HOLD;
    assign busy      = state != IDLE;
    assign out_sum   = acc;
    assign out_ovf   = ovf;
    // block sequencing: load on the first product, saturating add on the rest, hold result until consumed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_fire) begin
                    acc   <= AW'(in_data);
                    ovf   <= 1'b0;
                    cnt   <= eff_len - CW'(1);
                    state <= (eff_len == CW'(1)) ? HOLD : ACCUM;
                end
                ACCUM: if (in_fire) begin
                    acc <= sum[AW] ? '1 : sum[AW-1:0];
                    ovf <= ovf | sum[AW];
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= HOLD;
                end
                HOLD: if (out_ready) begin
                    state <= IDLE;
                    acc   <= '0;
                    ovf   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_product_accumulator.sv
// tb_mult_product_accumulator: directed checks of block summing, saturation, back-pressure and reset
module tb_mult_product_accumulator;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic [7:0]  len = '0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid, out_ovf, busy;
    logic [23:0] out_sum;
    logic        in_ready_s, out_valid_s, out_ovf_s, busy_s;
    logic [19:0] out_sum_s;
    int          total = 0;
    int          passed = 0;

    mult_product_accumulator dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .len(len), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_ovf(out_ovf), .busy(busy)
    );

    mult_product_accumulator #(.AW(20)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
        .len(len), .out_valid(out_valid_s), .out_ready(out_ready), .out_sum(out_sum_s),
        .out_ovf(out_ovf_s), .busy(busy_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d, input logic [7:0] l);
        in_valid = 1'b1;
        in_data  = d;
        len      = l;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        // reset
        tick();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_sum", 32'(out_sum), 0);
        chk("rst_ovf", 32'(out_ovf), 0);
        rst = 1'b1;
        #1;
        chk("rst_ready", 32'(in_ready), 1);

        // test 1: len=3, 100+200+300
        out_ready = 1'b1;
        chk("t1_ready0", 32'(in_ready), 1);
        push(16'd100, 8'd3);
        chk("t1_ready1", 32'(in_ready), 1);
        chk("t1_nv1", 32'(out_valid), 0);
        push(16'd200, 8'd3);
        chk("t1_ready2", 32'(in_ready), 1);
        push(16'd300, 8'd3);
        chk("t1_valid", 32'(out_valid), 1);
        chk("t1_sum", 32'(out_sum), 600);
        chk("t1_ovf", 32'(out_ovf), 0);
        chk("t1_hold_ready", 32'(in_ready), 0);
        tick();
        chk("t1_idle_valid", 32'(out_valid), 0);
        chk("t1_idle_busy", 32'(busy), 0);

        // test 2: len=0 treated as 1
        push(16'hFFFF, 8'd0);
        chk("t2_valid", 32'(out_valid), 1);
        chk("t2_sum", 32'(out_sum), 65535);
        chk("t2_ovf", 32'(out_ovf), 0);
        tick();
        chk("t2_idle", 32'(busy), 0);

        // test 3: max length block, and saturation on the 20-bit instance
        for (int i = 0; i < 255; i++) push(16'hFFFF, 8'd255);
        chk("t3_valid", 32'(out_valid), 1);
        chk("t3_sum", 32'(out_sum), 16711425);
        chk("t3_ovf", 32'(out_ovf), 0);
        chk("t3s_valid", 32'(out_valid_s), 1);
        chk("t3s_sum", 32'(out_sum_s), 32'hFFFFF);
        chk("t3s_ovf", 32'(out_ovf_s), 1);
        tick();
        for (int i = 0; i < 20; i++) push(16'hFFFF, 8'd20);
        chk("t3b_sum", 32'(out_sum), 1310700);
        chk("t3b_ovf", 32'(out_ovf), 0);
        chk("t3bs_valid", 32'(out_valid_s), 1);
        chk("t3bs_sum", 32'(out_sum_s), 32'hFFFFF);
        chk("t3bs_ovf", 32'(out_ovf_s), 1);
        tick();
        chk("t3_idle", 32'(busy_s), 0);

        // test 4: gapped input, result held under back-pressure
        out_ready = 1'b0;
        push(16'd10, 8'd3);
        tick();
        push(16'd20, 8'd3);
        tick();
        chk("t4_gap_ready", 32'(in_ready), 1);
        chk("t4_gap_nv", 32'(out_valid), 0);
        push(16'd30, 8'd3);
        in_valid = 1'b1;
        in_data  = 16'd7;
        len      = 8'd1;
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", 32'(out_valid), 1);
            chk("t4_hold_sum", 32'(out_sum), 60);
            chk("t4_hold_ready", 32'(in_ready), 0);
            tick();
        end
        chk("t4_hold_sum_end", 32'(out_sum), 60);
        out_ready = 1'b1;
        tick();
        chk("t4_after_valid", 32'(out_valid), 0);
        chk("t4_after_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        chk("t4_next_valid", 32'(out_valid), 1);
        chk("t4_next_sum", 32'(out_sum), 7);
        tick();
        chk("t4_idle", 32'(busy), 0);

        // test 5: asynchronous reset mid-block
        push(16'd50, 8'd4);
        push(16'd60, 8'd4);
        chk("t5_busy_pre", 32'(busy), 1);
        #2 rst = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(out_valid), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_sum", 32'(out_sum), 0);
        tick();
        #2 rst = 1'b1;
        tick();
        push(16'd5, 8'd2);
        push(16'd7, 8'd2);
        chk("t5_valid", 32'(out_valid), 1);
        chk("t5_sum", 32'(out_sum), 12);
        tick();

        // test 6: len changes mid-block are ignored
        push(16'd1, 8'd4);
        push(16'd2, 8'd1);
        push(16'd3, 8'd1);
        chk("t6_not_done", 32'(out_valid), 0);
        chk("t6_busy", 32'(busy), 1);
        push(16'd4, 8'd1);
        chk("t6_valid", 32'(out_valid), 1);
        chk("t6_sum", 32'(out_sum), 10);
        tick();
        push(16'd9, 8'd1);
        chk("t6_len1_valid", 32'(out_valid), 1);
        chk("t6_len1_sum", 32'(out_sum), 9);
        tick();
        chk("t6_idle", 32'(busy), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
